// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory handshake and
// registers the fetched word, its PC and PC+4 into the IF/ID boundary.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic [31:0] redirect_pc;
    logic        completion;
    logic [31:0] pc_plus4;

    // The read request drops while RESET is high so an in-flight access is abandoned.
    assign imem_read  = ~RESET & (state != HOLD);
    assign imem_addr  = pc;
    assign completion = imem_read & ~imem_busywait;
    assign pc_plus4   = pc + 32'd4;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_inst   <= '0;
            hold_pc     <= '0;
            redirect_pc <= '0;
            if_inst     <= NOP_INST;
            if_pc       <= '0;
            if_pc4      <= '0;
            if_valid    <= 1'b0;
        end else if (branch_taken) begin
            // Redirect flushes the IF/ID boundary regardless of stall.
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            case (state)
                FETCH: begin
                    if (completion) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end else begin
                        redirect_pc <= branch_target;
                        state       <= DRAIN;
                    end
                end
                HOLD: begin
                    pc    <= branch_target;
                    state <= FETCH;
                end
                DRAIN: begin
                    // A new redirect on the drain's final cycle goes straight to the newest target.
                    if (completion) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end else begin
                        redirect_pc <= branch_target;
                    end
                end
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (completion) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            hold_inst <= imem_readdata;
                            hold_pc   <= pc;
                            state     <= HOLD;
                        end else begin
                            if_inst  <= imem_readdata;
                            if_pc    <= pc;
                            if_pc4   <= pc_plus4;
                            if_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                        if_inst  <= NOP_INST;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_inst  <= hold_inst;
                        if_pc    <= hold_pc;
                        if_pc4   <= hold_pc + 32'd4;
                        if_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (completion) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory returns a scrambled address, a scoreboard tracks issued instructions.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_pc;
    logic        mon_stall;
    logic        mon_rst;

    if_stage dut (
        .CLK(CLK), .RESET(RESET), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_read(imem_read),
        .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
        .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_readdata = mem_word(imem_addr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every newly registered valid instruction must match the queue head.
    always @(posedge CLK) begin
        mon_stall = stall;
        mon_rst   = RESET;
        #2;
        if (!mon_rst && !RESET && !mon_stall && if_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got valid pc=%h, required no instruction", if_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (if_pc !== e) begin
                    errors++;
                    $display("FAIL sb_pc: got %h, required %h", if_pc, e);
                end
                checks++;
                if (if_inst !== mem_word(e)) begin
                    errors++;
                    $display("FAIL sb_inst: got %h, required %h", if_inst, mem_word(e));
                end
                checks++;
                if (if_pc4 !== e + 32'd4) begin
                    errors++;
                    $display("FAIL sb_pc4: got %h, required %h", if_pc4, e + 32'd4);
                end
            end
        end
    end

    task automatic test_reset();
        RESET = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_busywait = 1'b0;
        #1;
        checks++;
        if ({if_valid, if_inst, if_pc, if_pc4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b inst=%h pc=%h pc4=%h, required 0/%h/0/0", if_valid, if_inst, if_pc, if_pc4, NOP);
        end
        checks++;
        if ({imem_read, imem_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_imem: got read=%0b addr=%h, required 0/0", imem_read, imem_addr);
        end
        tick();
        RESET = 1'b0;
        #1;
        checks++;
        if ({imem_read, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL release_imem: got read=%0b addr=%h, required 1/0", imem_read, imem_addr);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL zw_addr: got %h, required %h", imem_addr, exp_pc);
            end
            sb.push_back(exp_pc);
            tick();
            checks++;
            if (if_valid !== 1'b1) begin
                errors++;
                $display("FAIL zw_gap: got valid=%0b, required 1", if_valid);
            end
            exp_pc += 4;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0C, mem_word(32'h0C)}) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b pc=%h inst=%h, required 1/0000000c/%h", if_valid, if_pc, if_inst, mem_word(32'h0C));
            end
            checks++;
            if ({imem_read, imem_addr} !== {1'b0, 32'h14}) begin
                errors++;
                $display("FAIL stall_imem: got read=%0b addr=%h, required 0/00000014", imem_read, imem_addr);
            end
        end
        stall = 1'b0;
        sb.push_back(32'h10);
        tick();
        sb.push_back(32'h14);
        tick();
        imem_busywait = 1'b1;
        exp_pc = 32'h18;
    endtask

    task automatic test_wait_states();
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 2; w++) begin
                checks++;
                if ({imem_read, imem_addr} !== {1'b1, exp_pc}) begin
                    errors++;
                    $display("FAIL ws_addr: got read=%0b addr=%h, required 1/%h", imem_read, imem_addr, exp_pc);
                end
                tick();
                checks++;
                if ({if_valid, if_inst} !== {1'b0, NOP}) begin
                    errors++;
                    $display("FAIL ws_bubble: got v=%0b inst=%h, required 0/%h", if_valid, if_inst, NOP);
                end
            end
            imem_busywait = 1'b0;
            sb.push_back(exp_pc);
            tick();
            imem_busywait = 1'b1;
            exp_pc += 4;
        end
    endtask

    task automatic test_branch_busy();
        branch_taken = 1'b1; branch_target = 32'h180;
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({if_valid, if_inst, imem_read, imem_addr} !== {1'b0, NOP, 1'b1, 32'h20}) begin
            errors++;
            $display("FAIL drain_hold: got v=%0b inst=%h read=%0b addr=%h, required 0/%h/1/00000020", if_valid, if_inst, imem_read, imem_addr, NOP);
        end
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        imem_busywait = 1'b0;
        tick();
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h100}) begin
            errors++;
            $display("FAIL drain_redirect: got v=%0b addr=%h, required 0/00000100", if_valid, imem_addr);
        end
        sb.push_back(32'h100);
        tick();
        imem_busywait = 1'b1;
        exp_pc = 32'h104;
    endtask

    task automatic test_branch_in_hold();
        stall = 1'b1; imem_busywait = 1'b0;
        tick();
        checks++;
        if ({imem_read, if_pc} !== {1'b0, 32'h100}) begin
            errors++;
            $display("FAIL hold_enter: got read=%0b pc=%h, required 0/00000100", imem_read, if_pc);
        end
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++;
        if ({if_valid, if_inst, imem_read, imem_addr} !== {1'b0, NOP, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL hold_flush: got v=%0b inst=%h read=%0b addr=%h, required 0/%h/1/00000040", if_valid, if_inst, imem_read, imem_addr, NOP);
        end
        sb.push_back(32'h40);
        tick();
        imem_busywait = 1'b1;
        exp_pc = 32'h44;
    endtask

    task automatic test_wrap_and_reset();
        imem_busywait = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_redirect: got v=%0b addr=%h, required 0/fffffffc", if_valid, imem_addr);
        end
        sb.push_back(32'hFFFF_FFFC);
        tick();
        checks++;
        if ({if_pc4, imem_addr} !== {32'h0, 32'h0}) begin
            errors++;
            $display("FAIL wrap_pc4: got pc4=%h addr=%h, required 0/0", if_pc4, imem_addr);
        end
        sb.push_back(32'h0);
        tick();
        sb.push_back(32'h4);
        tick();
        imem_busywait = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({if_valid, if_inst, if_pc, if_pc4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%0b inst=%h pc=%h pc4=%h, required 0/%h/0/0", if_valid, if_inst, if_pc, if_pc4, NOP);
        end
        checks++;
        if ({imem_read, imem_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL midreset_imem: got read=%0b addr=%h, required 0/0", imem_read, imem_addr);
        end
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_states();
        test_branch_busy();
        test_branch_in_hold();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
